fetch_unit: RTL

- Instruction-fetch stage directly downstream of program_counter.
- Consumes the registered PC `q`, issues one instruction-memory read per instruction over a req/gnt/rvalid handshake, and presents the fetched word to decode with a valid/ready handshake.
- Computes the next PC and drives it back onto the PC's `d` input: hold, increment or redirect, so the PC register advances only when a fetch is granted.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int          PC_INC_DEFAULT = 4;
  localparam logic [31:0] MISALIGN_INSTR = '0;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of PC, instruction-memory and decode handshake signals around the fetch stage.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_misalign;

  // master is the fetch unit; slave is the PC/memory/decode environment
  modport master (
    input  pc, redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_misalign
  );

  modport slave (
    output pc, redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_misalign
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read per instruction, registered handoff to decode,
// and next-PC selection (hold / increment / redirect) for the upstream PC register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                PC_INC   = PC_INC_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         clr_n,
  fetch_unit_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  logic              req_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic              misaligned;
  logic [ADDR_W-1:0] pc_inc;

  assign misaligned = |bus.pc[1:0];
  assign pc_inc     = bus.pc + ADDR_W'(PC_INC);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    mis_d      = mis_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    req_c      = 1'b0;
    pc_next_c  = bus.pc;

    unique case (state_q)
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_next_c = bus.redirect_pc;
        end else if (misaligned) begin
          // A misaligned PC never reaches memory; decode gets a flagged null word instead.
          valid_d    = 1'b1;
          mis_d      = 1'b1;
          instr_d    = DATA_W'(MISALIGN_INSTR);
          instr_pc_d = bus.pc;
          state_d    = HOLD;
        end else begin
          req_c = 1'b1;
          if (bus.imem_gnt) begin
            pc_next_c  = pc_inc;
            instr_pc_d = bus.pc;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_next_c = bus.redirect_pc;
          state_d   = bus.imem_rvalid ? FETCH : DRAIN;
        end else if (bus.imem_rvalid) begin
          valid_d = 1'b1;
          mis_d   = 1'b0;
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_next_c = bus.redirect_pc;
          valid_d   = 1'b0;
          state_d   = FETCH;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) begin
          pc_next_c = bus.redirect_pc;
        end
        // The stale response retires the outstanding request even if a new redirect arrives.
        if (bus.imem_rvalid) begin
          state_d = FETCH;
        end
      end
    endcase

    if (!clr_n) begin
      req_c     = 1'b0;
      pc_next_c = RESET_PC;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= FETCH;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.imem_req       = req_c;
  assign bus.imem_addr      = bus.pc;
  assign bus.pc_next        = pc_next_c;
  assign bus.instr_valid    = valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_misalign = mis_q;

endmodule
